// File: rtl/cdc_sync_filter.sv
// rtl/cdc_sync_filter.sv - per-channel flop-chain synchroniser with stability filter and edge/glitch pulses
module cdc_sync_filter #(
  parameter int                  CHANNELS      = 8,
  parameter int                  SYNC_STAGES   = 3,
  parameter int                  FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] glitch
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  (* ASYNC_REG = "true" *) logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sl;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VALUE;
    end else begin
      sync_q[0] <= in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sl = sync_q[SYNC_STAGES-1];

  // cnt counts consecutive cycles sl has disagreed with out; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= RESET_VALUE;
      rise   <= '0;
      fall   <= '0;
      glitch <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sl[i] == out[i]) begin
          cnt_q[i]  <= '0;
          glitch[i] <= (cnt_q[i] != '0);
          rise[i]   <= 1'b0;
          fall[i]   <= 1'b0;
        end else if (cnt_q[i] == CNT_LAST) begin
          out[i]    <= sl[i];
          cnt_q[i]  <= '0;
          rise[i]   <= sl[i];
          fall[i]   <= ~sl[i];
          glitch[i] <= 1'b0;
        end else begin
          cnt_q[i]  <= cnt_q[i] + CNT_W'(1);
          rise[i]   <= 1'b0;
          fall[i]   <= 1'b0;
          glitch[i] <= 1'b0;
        end
      end
    end
  end

endmodule
